// File: rtl/mux_sel_arbiter_pkg.sv
// Shared types for the two-source round-robin mux arbiter.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2
  } state_t;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

endpackage

// File: rtl/mux_sel_arbiter_if.sv
// Request/data/grant bundle between the two sources and the arbiter.
// Optional macro ARB_LOCK_EN adds the lock input.
interface mux_sel_arbiter_if #(parameter int DATA_W = 8);

  logic              req_a;
  logic [DATA_W-1:0] data_a;
  logic              req_b;
  logic [DATA_W-1:0] data_b;
  logic              gnt_a;
  logic              gnt_b;
  logic              sel;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
`ifdef ARB_LOCK_EN
  logic              lock;

  modport master (output req_a, data_a, req_b, data_b, lock,
                  input  gnt_a, gnt_b, sel, out_data, out_valid);
  modport slave  (input  req_a, data_a, req_b, data_b, lock,
                  output gnt_a, gnt_b, sel, out_data, out_valid);
`else
  modport master (output req_a, data_a, req_b, data_b,
                  input  gnt_a, gnt_b, sel, out_data, out_valid);
  modport slave  (input  req_a, data_a, req_b, data_b,
                  output gnt_a, gnt_b, sel, out_data, out_valid);
`endif

endinterface

// File: rtl/mux_sel_arbiter_rr_pick.sv
// Next-owner choice from IDLE: a lone requester wins, contention goes to
// the source that did not own the mux last.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last_owner,
  output logic pick_valid,
  output logic pick_owner
);

  // Round-robin pick between the two requesters
  always_comb begin
    pick_valid = req_a | req_b;
    if (req_a && req_b)
      pick_owner = (last_owner == OWNER_A) ? OWNER_B : OWNER_A;
    else if (req_b)
      pick_owner = OWNER_B;
    else
      pick_owner = OWNER_A;
  end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter for the shared A/B 2:1 mux datapath. Grants are
// bounded to MAX_HOLD beats while the other source waits.
// Optional macro ARB_LOCK_EN: a lock input on the bus suppresses rotation
// while the owner holds it.
//
// state    | meaning
// ST_IDLE  | no owner, sel keeps its last value
// ST_OWN_A | A granted, sel=0
// ST_OWN_B | B granted, sel=1
module mux_sel_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  mux_sel_arbiter_if.slave    bus
);

  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

  state_t            state, next_state;
  logic [CNT_W-1:0]  hold_cnt, cnt_next, cnt_inc;
  logic              last_owner, owner_next;
  logic              sel_q, sel_next;
  logic [DATA_W-1:0] out_data_q, beat_data;
  logic              out_valid_q, beat;
  logic              pick_valid, pick_owner;
  logic              rotate_ok, at_max;

`ifdef ARB_LOCK_EN
  assign rotate_ok = ~bus.lock;
`else
  assign rotate_ok = 1'b1;
`endif

  assign cnt_inc = hold_cnt + CNT_W'(1);
  assign at_max  = (cnt_inc == HOLD_MAX);

  rr_pick u_pick (
    .req_a      (bus.req_a),
    .req_b      (bus.req_b),
    .last_owner (last_owner),
    .pick_valid (pick_valid),
    .pick_owner (pick_owner)
  );

  // Next state: idle pick, release on request drop, rotate at burst limit
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (pick_valid)
          next_state = (pick_owner == OWNER_B) ? ST_OWN_B : ST_OWN_A;
      end
      ST_OWN_A: begin
        if (!bus.req_a)
          next_state = bus.req_b ? ST_OWN_B : ST_IDLE;
        else if (at_max && bus.req_b && rotate_ok)
          next_state = ST_OWN_B;
      end
      ST_OWN_B: begin
        if (!bus.req_b)
          next_state = bus.req_a ? ST_OWN_A : ST_IDLE;
        else if (at_max && bus.req_a && rotate_ok)
          next_state = ST_OWN_A;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Beat detection, burst counter, select and owner bookkeeping
  always_comb begin
    beat = ((state == ST_OWN_A) && bus.req_a) ||
           ((state == ST_OWN_B) && bus.req_b);
    beat_data = (state == ST_OWN_B) ? bus.data_b : bus.data_a;

    cnt_next = hold_cnt;
    if (next_state != state)
      cnt_next = '0;
    else if (beat)
      cnt_next = at_max ? '0 : cnt_inc;

    owner_next = last_owner;
    sel_next   = sel_q;
    if (next_state == ST_OWN_A) begin
      owner_next = OWNER_A;
      sel_next   = 1'b0;
    end else if (next_state == ST_OWN_B) begin
      owner_next = OWNER_B;
      sel_next   = 1'b1;
    end
  end

  // State register with counter, owner history and select
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      hold_cnt   <= '0;
      last_owner <= OWNER_B;
      sel_q      <= 1'b0;
    end else begin
      state      <= next_state;
      hold_cnt   <= cnt_next;
      last_owner <= owner_next;
      sel_q      <= sel_next;
    end
  end

  // Output data register: capture the granted source on each beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= beat;
      if (beat)
        out_data_q <= beat_data;
    end
  end

  assign bus.gnt_a     = (state == ST_OWN_A);
  assign bus.gnt_b     = (state == ST_OWN_B);
  assign bus.sel       = sel_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Self-checking bench for mux_sel_arbiter (DATA_W=8, MAX_HOLD=4) against a
// cycle-level behavioural model of the arbitration rules.
module tb_mux_sel_arbiter;

  localparam int DW = 8;
  localparam int MH = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic lock_v;
  always #5 clk = ~clk;

  mux_sel_arbiter_if #(.DATA_W(DW)) bus ();

`ifdef ARB_LOCK_EN
  assign bus.lock = lock_v;
`endif

  mux_sel_arbiter #(.DATA_W(DW), .MAX_HOLD(MH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // model: owner 0=none 1=A 2=B, run = beats in current grant mod MH
  int          m_own, m_last, m_run;
  logic        m_sel, m_valid;
  logic [DW-1:0] m_out;

  function automatic logic [11:0] obs();
    return {bus.gnt_a, bus.gnt_b, bus.sel, bus.out_valid, bus.out_data};
  endfunction

  function automatic logic [11:0] expv();
    return {m_own == 1, m_own == 2, m_sel, m_valid, m_out};
  endfunction

  task automatic model_reset();
    m_own = 0; m_last = 2; m_run = 0;
    m_sel = 1'b0; m_valid = 1'b0; m_out = '0;
  endtask

  task automatic drive(input bit ra, input bit rb, input logic [DW-1:0] da,
                       input logic [DW-1:0] db, input bit lk);
    bus.req_a = ra; bus.req_b = rb; bus.data_a = da; bus.data_b = db;
    lock_v = lk;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 8'h00, 8'h00, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  // advance model by one clock from present inputs, then clock the DUT
  task automatic step();
    int  nxt;
    bit  mine, other, lk;
    lk = 1'b0;
`ifdef ARB_LOCK_EN
    lk = lock_v;
`endif
    m_valid = 1'b0;
    nxt = m_own;
    if (m_own == 0) begin
      if (bus.req_a && bus.req_b) nxt = (m_last == 1) ? 2 : 1;
      else if (bus.req_a)         nxt = 1;
      else if (bus.req_b)         nxt = 2;
    end else begin
      mine  = (m_own == 1) ? bus.req_a : bus.req_b;
      other = (m_own == 1) ? bus.req_b : bus.req_a;
      if (!mine) begin
        nxt = other ? 3 - m_own : 0;
      end else begin
        m_valid = 1'b1;
        m_out   = (m_own == 1) ? bus.data_a : bus.data_b;
        m_run++;
        if (m_run == MH) begin
          m_run = 0;
          if (other && !lk) nxt = 3 - m_own;
        end
      end
    end
    if (nxt != m_own) begin
      m_run = 0;
      if (nxt != 0) begin
        m_last = nxt;
        m_sel  = (nxt == 2);
      end
    end
    m_own = nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1, 1, 8'hAA, 8'h55, 0);
    #3;
    checks++;
    if (obs() !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=%h", obs(), 12'h000);
    end
    do_reset();
  endtask

  task automatic test_single_a();
    do_reset();
    drive(1, 0, 8'h3C, 8'h55, 0);
    step();
    checks++;
    if ({bus.gnt_a, bus.gnt_b, bus.sel, bus.out_valid} !== 4'b1000) begin
      errors++;
      $display("FAIL single_a_grant got=%b exp=1000", {bus.gnt_a, bus.gnt_b, bus.sel, bus.out_valid});
    end
    step();
    checks++;
    if ({bus.gnt_b, bus.out_valid, bus.out_data} !== {1'b0, 1'b1, 8'h3C}) begin
      errors++;
      $display("FAIL single_a_data got=%h exp=%h", {bus.gnt_b, bus.out_valid, bus.out_data}, {1'b0, 1'b1, 8'h3C});
    end
    checks++;
    if (obs() !== expv()) begin
      errors++;
      $display("FAIL single_a_model got=%h exp=%h", obs(), expv());
    end
  endtask

  task automatic test_contention();
    do_reset();
    for (int i = 1; i <= 26; i++) begin
      drive(1, 1, 8'($urandom), 8'($urandom), 0);
      step();
      checks++;
      if (bus.sel !== 1'(((i - 1) / MH) % 2) || bus.gnt_b !== 1'(((i - 1) / MH) % 2)) begin
        errors++;
        $display("FAIL contention_rotation cycle=%0d got sel=%b gnt_b=%b exp=%0d", i, bus.sel, bus.gnt_b, ((i - 1) / MH) % 2);
      end
      if (i >= 2) begin
        checks++;
        if (bus.out_valid !== 1'b1) begin
          errors++;
          $display("FAIL contention_no_gap cycle=%0d got=%b exp=1", i, bus.out_valid);
        end
      end
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL contention_model cycle=%0d got=%h exp=%h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_solo_wrap();
    int nvalid = 0;
    do_reset();
    for (int i = 1; i <= 11; i++) begin
      drive(1, 0, 8'(i * 7), 8'hEE, 0);
      step();
      if (bus.out_valid === 1'b1) nvalid++;
      checks++;
      if (bus.gnt_a !== 1'b1 || obs() !== expv()) begin
        errors++;
        $display("FAIL solo_wrap cycle=%0d got=%h exp=%h", i, obs(), expv());
      end
    end
    checks++;
    if (nvalid !== 10) begin
      errors++;
      $display("FAIL solo_wrap_beats got=%0d exp=10", nvalid);
    end
  endtask

  task automatic test_drop();
    do_reset();
    drive(1, 1, 8'h11, 8'h22, 0); step();
    drive(1, 1, 8'h12, 8'h22, 0); step();
    drive(1, 1, 8'h13, 8'h22, 0); step();
    drive(0, 1, 8'h14, 8'h23, 0); step();
    checks++;
    if ({bus.gnt_a, bus.gnt_b, bus.sel, bus.out_valid} !== 4'b0110) begin
      errors++;
      $display("FAIL drop_handover got=%b exp=0110", {bus.gnt_a, bus.gnt_b, bus.sel, bus.out_valid});
    end
    drive(0, 1, 8'h15, 8'h24, 0); step();
    checks++;
    if ({bus.out_valid, bus.out_data} !== {1'b1, 8'h24} || obs() !== expv()) begin
      errors++;
      $display("FAIL drop_b_beat got=%h exp=%h", obs(), expv());
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(0, 1, 8'h00, 8'hB1, 0); step();
    drive(0, 1, 8'h00, 8'hB2, 0); step();
    drive(0, 1, 8'h00, 8'hB3, 0); step();
    checks++;
    if (obs() !== expv()) begin
      errors++;
      $display("FAIL async_pre got=%h exp=%h", obs(), expv());
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (obs() !== 12'h000) begin
      errors++;
      $display("FAIL async_reset got=%h exp=%h", obs(), 12'h000);
    end
    model_reset();
    drive(1, 1, 8'hA7, 8'hB7, 0);
    #2 rst_n = 1'b1;
    step();
    checks++;
    if ({bus.gnt_a, bus.gnt_b} !== 2'b10 || obs() !== expv()) begin
      errors++;
      $display("FAIL async_release_a_first got=%h exp=%h", obs(), expv());
    end
    step();
    checks++;
    if (obs() !== expv()) begin
      errors++;
      $display("FAIL async_after got=%h exp=%h", obs(), expv());
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
            8'($urandom), 8'($urandom), $urandom_range(0, 5) == 0);
      step();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL random cycle=%0d got=%h exp=%h", i, obs(), expv());
      end
    end
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    drive(1, 1, 8'h40, 8'h80, 1); step();
    for (int i = 1; i <= 12; i++) begin
      drive(1, 1, 8'(8'h40 + i), 8'h80, 1);
      step();
      checks++;
      if (bus.gnt_a !== 1'b1 || obs() !== expv()) begin
        errors++;
        $display("FAIL lock_hold beat=%0d got=%h exp=%h", i, obs(), expv());
      end
    end
    for (int k = 1; k <= MH; k++) begin
      drive(1, 1, 8'h60, 8'h90, 0);
      step();
      checks++;
      if (bus.gnt_b !== 1'(k == MH) || obs() !== expv()) begin
        errors++;
        $display("FAIL lock_release k=%0d got=%h exp=%h", k, obs(), expv());
      end
    end
  endtask
`endif

  initial begin
    lock_v = 1'b0;
    model_reset();
    test_reset();
    test_single_a();
    test_contention();
    test_solo_wrap();
    test_drop();
    test_async_reset();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
